// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// It has no adder of its own: it drives a shared external adder, one add per cycle.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NEG_A  = 3'd1;
  localparam logic [2:0] S_NEG_B  = 3'd2;
  localparam logic [2:0] S_ITER   = 3'd3;
  localparam logic [2:0] S_FIX_LO = 3'd4;
  localparam logic [2:0] S_FIX_HI = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]       state, state_n;
  logic [WIDTH-1:0] opa, opa_n, opb, opb_n;
  logic [WIDTH-1:0] p, p_n, q, q_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sign_a, sign_a_n, sign_b, sign_b_n;
  logic             is_div, is_div_n, fix_c, fix_c_n, dbz_n;
  logic             finish, sa, sb;

  assign busy = (state == S_NEG_A) || (state == S_NEG_B) || (state == S_ITER) ||
                (state == S_FIX_LO) || (state == S_FIX_HI);
  assign done = (state == S_DONE);

  always_comb begin
    state_n  = state;
    opa_n    = opa;
    opb_n    = opb;
    p_n      = p;
    q_n      = q;
    cnt_n    = cnt;
    sign_a_n = sign_a;
    sign_b_n = sign_b;
    is_div_n = is_div;
    fix_c_n  = fix_c;
    dbz_n    = div_by_zero;
    hi_n     = hi;
    lo_n     = lo;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    finish   = 1'b0;
    sa       = src_a[WIDTH-1] & op[0];
    sb       = src_b[WIDTH-1] & op[0];
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          opa_n    = src_a;
          opb_n    = src_b;
          sign_a_n = sa;
          sign_b_n = sb;
          is_div_n = op[1];
          dbz_n    = op[1] && (src_b == '0);
          cnt_n    = '0;
          if (op[1] && (src_b == '0)) begin
            p_n     = src_a;
            q_n     = '1;
            state_n = S_DONE;
            finish  = 1'b1;
          end else if (sa) begin
            state_n = S_NEG_A;
          end else if (sb) begin
            state_n = S_NEG_B;
          end else begin
            p_n     = '0;
            q_n     = op[1] ? src_a : src_b;
            state_n = S_ITER;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_NEG_A: begin
        add_a   = ~opa;
        add_cin = 1'b1;
        opa_n   = add_sum;
        if (sign_b) begin
          state_n = S_NEG_B;
        end else begin
          p_n     = '0;
          q_n     = is_div ? add_sum : opb;
          state_n = S_ITER;
        end
      end
      S_NEG_B: begin
        add_a   = ~opb;
        add_cin = 1'b1;
        opb_n   = add_sum;
        p_n     = '0;
        q_n     = is_div ? opa : add_sum;
        state_n = S_ITER;
      end
      S_ITER: begin
        cnt_n = cnt + 1'b1;
        if (!is_div) begin
          add_a = p;
          add_b = q[0] ? opa : '0;
          p_n   = {add_cout, add_sum[WIDTH-1:1]};
          q_n   = {add_sum[0], q[WIDTH-1:1]};
        end else begin
          // Trial subtract of the divisor from the shifted remainder; bit W of the
          // shifted remainder forces the subtract even when the adder shows no carry.
          add_a   = {p[WIDTH-2:0], q[WIDTH-1]};
          add_b   = ~opb;
          add_cin = 1'b1;
          if (p[WIDTH-1] || add_cout) begin
            p_n = add_sum;
            q_n = {q[WIDTH-2:0], 1'b1};
          end else begin
            p_n = {p[WIDTH-2:0], q[WIDTH-1]};
            q_n = {q[WIDTH-2:0], 1'b0};
          end
        end
        if (cnt == CNT_W'(WIDTH - 1)) begin
          if (sign_a ^ sign_b) begin
            state_n = S_FIX_LO;
          end else if (is_div && sign_a) begin
            state_n = S_FIX_HI;
          end else begin
            state_n = S_DONE;
            finish  = 1'b1;
          end
        end
      end
      S_FIX_LO: begin
        add_a   = ~q;
        add_cin = 1'b1;
        q_n     = add_sum;
        fix_c_n = add_cout;
        if (!is_div || sign_a) begin
          state_n = S_FIX_HI;
        end else begin
          state_n = S_DONE;
          finish  = 1'b1;
        end
      end
      S_FIX_HI: begin
        // Product high word takes the low-word carry; remainder is a plain negate.
        add_a   = ~p;
        add_cin = is_div ? 1'b1 : fix_c;
        p_n     = add_sum;
        state_n = S_DONE;
        finish  = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    if (finish) begin
      hi_n = p_n;
      lo_n = q_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      opa         <= '0;
      opb         <= '0;
      p           <= '0;
      q           <= '0;
      cnt         <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      is_div      <= 1'b0;
      fix_c       <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state       <= state_n;
      opa         <= opa_n;
      opb         <= opb_n;
      p           <= p_n;
      q           <= q_n;
      cnt         <= cnt_n;
      sign_a      <= sign_a_n;
      sign_b      <= sign_b_n;
      is_div      <= is_div_n;
      fix_c       <= fix_c_n;
      div_by_zero <= dbz_n;
      hi          <= hi_n;
      lo          <= lo_n;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, corner sequences,
// and random operations against a 64-bit arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int tests = 0;
  int fails = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Shared adder as seen by the sequencer.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; latency counts the stages each rule adds.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic z,
                       output int lat);
    longint sx, sy, r64;
    longint unsigned ux, uy, u64;
    logic sa, sb;
    sa = o[0] & a[31];
    sb = o[0] & b[31];
    z  = 1'b0;
    lat = 1 + int'(sa) + int'(sb) + 32;
    sx = longint'($signed(a));
    sy = longint'($signed(b));
    ux = {32'd0, a};
    uy = {32'd0, b};
    case (o)
      2'b00: begin u64 = ux * uy; {h, l} = u64; end
      2'b01: begin
        r64 = sx * sy; {h, l} = r64;
        if (sa ^ sb) lat += 2;
      end
      default: begin
        if (b == 0) begin
          h = a; l = 32'hFFFF_FFFF; z = 1'b1; lat = 1;
        end else if (o == 2'b10) begin
          l = 32'(ux / uy); h = 32'(ux % uy);
        end else begin
          l = 32'(sx / sy); h = 32'(sx % sy);
          lat += int'(sa ^ sb) + int'(sa);
        end
      end
    endcase
  endtask

  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input logic ez, input int elat, input bit intrude);
    int k;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    if (elat > 1) chk({nm, " busy_after_accept"}, 64'(busy), 64'd1);
    while (!done && k < 100) begin
      if (intrude && k == 5) begin
        chk({nm, " hi_hold"}, 64'(hi), 64'(prev_hi));
        chk({nm, " lo_hold"}, 64'(lo), 64'(prev_lo));
        start = 1'b1; op = 2'($urandom_range(0, 3));
        src_a = $urandom; src_b = $urandom;
      end
      if (intrude && k == 7) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    chk({nm, " latency"}, 64'(k), 64'(elat));
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    chk({nm, " dbz"}, 64'(div_by_zero), 64'(ez));
    chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
    prev_hi = eh;
    prev_lo = el;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " busy"}, 64'(busy), 64'd0);
    chk({nm, " done"}, 64'(done), 64'd0);
    chk({nm, " hi"}, 64'(hi), 64'd0);
    chk({nm, " lo"}, 64'(lo), 64'd0);
    chk({nm, " dbz"}, 64'(div_by_zero), 64'd0);
    chk({nm, " add_a"}, 64'(add_a), 64'd0);
    chk({nm, " add_b"}, 64'(add_b), 64'd0);
    chk({nm, " add_cin"}, 64'(add_cin), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] edges[4];
    edges[0] = 32'h8000_0000; edges[1] = 32'hFFFF_FFFF;
    edges[2] = 32'h7FFF_FFFF; edges[3] = 32'h0000_0001;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 20));
      2: return -32'($urandom_range(1, 20));
      default: return edges[$urandom_range(0, 3)];
    endcase
  endfunction

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, eh, el;
    logic        ez;
    int          elat;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
    vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 36};
    vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 36};
    vecs[3] = '{2'b10, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0, 33};
    vecs[4] = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};
    vecs[5] = '{2'b00, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0, 33};
    vecs[6] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 36};
    vecs[7] = '{2'b01, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd0,         32'd21,        1'b0, 35};
    vecs[8] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 35};

    rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, issued back to back from the DONE cycle.
    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat, 1'b0);

    // done lasts one cycle, then IDLE.
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Start during ITER is ignored.
    do_op("intrude", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b1);

    // Reset at ITER cycle 10 after a divide-by-zero left dbz set.
    do_op("dbz_pre", 2'b11, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
    start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_state("mid_reset");
    rst = 1'b0;
    prev_hi = '0;
    prev_lo = '0;

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      if (ro[1] && $urandom_range(0, 9) == 0) rb = '0;
      model(ro, ra, rb, eh, el, ez, elat);
      do_op($sformatf("rnd%0d", i), ro, ra, rb, eh, el, ez, elat, (i % 10 == 3) && !ez);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        chk($sformatf("rnd%0d done_pulse", i), 64'(done), 64'd0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
